// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel input block: keypad geometry,
// entry sizing and the keypad scan states.
package panel_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS,
        HELD,
        RELEASE
    } scan_state_t;

    localparam int KP_ROWS    = 4;
    localparam int KP_COLS    = 4;
    localparam int KEY_W      = 4;
    localparam int ENTRY_W    = 16;
    localparam int MAX_DIGITS = 4;

    // Active-low row drive pattern with only the selected row pulled low.
    function automatic logic [KP_ROWS-1:0] row_drive(input logic [1:0] row);
        return ~(KP_ROWS'(1) << row);
    endfunction

    function automatic logic [1:0] col_index(input logic [KP_COLS-1:0] onehot);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < KP_COLS; i++) begin
            if (onehot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One function button: 2-FF synchroniser, tick-paced debounce counter and a
// one-clk pulse on each accepted press (released -> pressed).
module debounce_bit #(
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw_n,
    output logic stable,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] count;
    logic          level;
    logic          flip;

    assign level = sync_q[1];
    assign flip  = tick && (level != stable) && (count == CW'(DEBOUNCE_CNT - 1));

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
            sync_q <= {sync_q[0], raw_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            stable      <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= flip && stable;
            if (tick) begin
                if (level == stable) begin
                    count <= '0;
                end else if (flip) begin
                    stable <= level;
                    count  <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/panel_input.sv
// Front-panel input producer: scans a 4x4 hex keypad into a 16-bit entry and
// turns the raw function buttons into debounced one-clk press pulses.
module panel_input
    import panel_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 16,
    parameter int NUM_BTN      = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [KP_ROWS-1:0]   kp_row_n,
    input  logic [KP_COLS-1:0]   kp_col_n,
    input  logic [NUM_BTN-1:0]   btn_n,
    output logic [NUM_BTN-1:0]   btn_pulse,
    output logic [ENTRY_W-1:0]   user_input,
    output logic                 input_valid,
    output logic [2:0]           digit_count
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic [PW-1:0]      presc;
    logic               tick;
    logic [KP_COLS-1:0] col_meta;
    logic [KP_COLS-1:0] col_s;
    logic [NUM_BTN-1:0] unused_stable;

    scan_state_t        state, state_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic [1:0]         row;
    logic [1:0]         key_col;
    logic               advance, latch, accept;

    logic [KP_COLS-1:0] col_low;
    logic               one_low, same_key, all_high, count_done;

    assign tick = (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc <= '0;
        else        presc <= tick ? '0 : presc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= kp_col_n;
            col_s    <= col_meta;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_debounce (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .raw_n       (btn_n[i]),
            .stable      (unused_stable[i]),
            .press_pulse (btn_pulse[i])
        );
    end

    // A new row is only sampled on the next tick, which covers the synchroniser
    // latency as long as SCAN_DIV is at least 3.
    assign col_low    = ~col_s;
    assign one_low    = (col_low != '0) && ((col_low & (col_low - 1'b1)) == '0);
    assign same_key   = (col_low == (KP_COLS'(1) << key_col));
    assign all_high   = &col_s;
    assign count_done = (count == CW'(DEBOUNCE_CNT - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_nxt = state;
        count_nxt = count;
        advance   = 1'b0;
        latch     = 1'b0;
        accept    = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (one_low) begin
                        state_nxt = PRESS;
                        count_nxt = CW'(1);
                        latch     = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                PRESS: begin
                    if (!same_key) begin
                        state_nxt = SCAN;
                        count_nxt = '0;
                        advance   = 1'b1;
                    end else if (count_done) begin
                        state_nxt = HELD;
                        count_nxt = '0;
                        accept    = 1'b1;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
                HELD: begin
                    if (all_high) begin
                        state_nxt = RELEASE;
                        count_nxt = CW'(1);
                    end
                end
                RELEASE: begin
                    if (!all_high) begin
                        state_nxt = HELD;
                        count_nxt = '0;
                    end else if (count_done) begin
                        state_nxt = SCAN;
                        count_nxt = '0;
                        advance   = 1'b1;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // The row stays put from PRESS until the release has been debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            kp_row_n <= row_drive(2'd0);
            key_col  <= '0;
        end else begin
            if (latch) key_col <= col_index(col_low);
            if (advance) begin
                row      <= row + 2'd1;
                kp_row_n <= row_drive(row + 2'd1);
            end
        end
    end

    // A button strobe consumes the entry, so the clear outranks a digit arriving with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            user_input  <= '0;
            digit_count <= '0;
        end else if (|btn_pulse) begin
            user_input  <= '0;
            digit_count <= '0;
        end else if (accept) begin
            user_input  <= {user_input[ENTRY_W-KEY_W-1:0], row, key_col};
            if (digit_count != 3'(MAX_DIGITS)) digit_count <= digit_count + 1'b1;
        end
    end

    assign input_valid = (digit_count != '0);

endmodule

// File: tb/tb_panel_input.sv
// Self-checking bench for panel_input: tick-level behavioural model of the keypad
// and buttons driven by directed scenarios plus a randomized key/button phase.
module tb_panel_input;

    localparam int SCAN_DIV = 4;
    localparam int DC       = 3;
    localparam int NB       = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    kp_row_n;
    logic [3:0]    kp_col_n;
    logic [NB-1:0] btn_n;
    logic [NB-1:0] btn_pulse;
    logic [15:0]   user_input;
    logic          input_valid;
    logic [2:0]    digit_count;

    logic [15:0]   keys_down;   // bit {row,col} set while that key is held

    int total = 0;
    int bad   = 0;

    // Model state, advanced once per scan tick.
    int            m_row;
    bit            m_locked;
    int            m_run;
    int            m_col;
    int            m_quiet;
    logic [15:0]   m_entry;
    int            m_count;
    bit [NB-1:0]   m_stable;
    int            m_brun[NB];
    bit            pending_clear;
    int            seen0;

    panel_input #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DC),
        .NUM_BTN      (NB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kp_row_n    (kp_row_n),
        .kp_col_n    (kp_col_n),
        .btn_n       (btn_n),
        .btn_pulse   (btn_pulse),
        .user_input  (user_input),
        .input_valid (input_valid),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    // Passive keypad matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        kp_col_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp_row_n[r] && keys_down[r*4+c]) kp_col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_row         = 0;
        m_locked      = 1'b0;
        m_run         = 0;
        m_col         = 0;
        m_quiet       = 0;
        m_entry       = '0;
        m_count       = 0;
        m_stable      = '1;
        pending_clear = 1'b0;
        for (int i = 0; i < NB; i++) m_brun[i] = 0;
    endtask

    task automatic model_tick(output bit [NB-1:0] pulse);
        bit [3:0] cl;
        pulse = '0;
        for (int i = 0; i < NB; i++) begin
            if (btn_n[i] != m_stable[i]) begin
                m_brun[i]++;
                if (m_brun[i] == DC) begin
                    m_stable[i] = btn_n[i];
                    m_brun[i]   = 0;
                    if (!btn_n[i]) pulse[i] = 1'b1;
                end
            end else begin
                m_brun[i] = 0;
            end
        end
        cl = keys_down[m_row*4 +: 4];
        if (!m_locked) begin
            if (m_run == 0) begin
                if ($countones(cl) == 1) begin
                    for (int c = 0; c < 4; c++) if (cl[c]) m_col = c;
                    m_run = 1;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end else if (cl == (4'b0001 << m_col)) begin
                m_run++;
                if (m_run == DC) begin
                    m_entry  = {m_entry[11:0], 4'(m_row * 4 + m_col)};
                    m_count  = (m_count < 4) ? m_count + 1 : 4;
                    m_locked = 1'b1;
                    m_run    = 0;
                    m_quiet  = 0;
                end
            end else begin
                m_run = 0;
                m_row = (m_row + 1) % 4;
            end
        end else if (cl == 4'b0000) begin
            m_quiet++;
            if (m_quiet == DC) begin
                m_locked = 1'b0;
                m_quiet  = 0;
                m_row    = (m_row + 1) % 4;
            end
        end else begin
            m_quiet = 0;
        end
    endtask

    // Advance one scan tick; ends #1 after the tick edge, where its results show.
    task automatic step_tick();
        bit [NB-1:0] pulse;
        logic [3:0]  exp_row;
        for (int i = 0; i < SCAN_DIV; i++) begin
            @(posedge clk);
            #1;
            if (btn_pulse[0]) seen0++;
            if (i == 0 && pending_clear) begin
                check("clear_user_input", user_input, 32'h0);
                check("clear_input_valid", input_valid, 32'h0);
            end
            if (i < SCAN_DIV - 1) check("pulse_idle", btn_pulse, 32'h0);
        end
        model_tick(pulse);
        exp_row = ~(4'b0001 << m_row);
        check("kp_row_n", kp_row_n, exp_row);
        check("btn_pulse", btn_pulse, pulse);
        check("user_input", user_input, m_entry);
        check("digit_count", digit_count, m_count);
        check("input_valid", input_valid, (m_count != 0));
        pending_clear = |pulse;
        if (pending_clear) begin
            m_entry = '0;
            m_count = 0;
        end
    endtask

    task automatic hold(input int n);
        repeat (n) step_tick();
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_kp_row_n"}, kp_row_n, 32'hE);
        check({phase, "_btn_pulse"}, btn_pulse, 32'h0);
        check({phase, "_user_input"}, user_input, 32'h0);
        check({phase, "_input_valid"}, input_valid, 32'h0);
        check({phase, "_digit_count"}, digit_count, 32'h0);
    endtask

    initial begin
        int seen_rows[4];
        int timer;
        int b;
        logic [3:0] pat;

        rst_n     = 1'b0;
        keys_down = '0;
        btn_n     = '1;
        seen0     = 0;
        model_reset();
        #23;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("post_rst");

        // Single key row1/col2 held then released: exactly one digit 6.
        keys_down = 16'h0040;
        hold(10);
        keys_down = '0;
        hold(5);
        check("key6_user_input", user_input, 32'h0006);
        check("key6_digit_count", digit_count, 32'd1);
        check("key6_input_valid", input_valid, 32'd1);

        // Keys 1..5: oldest digits shift out, count saturates.
        for (int k = 1; k <= 5; k++) begin
            keys_down = 16'h0001 << k;
            hold(8);
            keys_down = '0;
            hold(5);
        end
        check("seq_user_input", user_input, 32'h2345);
        check("seq_digit_count", digit_count, 32'd4);

        // Clear with btn[5], enter A, consume with btn[3].
        btn_n[5] = 1'b0;
        hold(4);
        btn_n[5] = 1'b1;
        hold(4);
        keys_down = 16'h0400;
        hold(8);
        keys_down = '0;
        hold(5);
        check("keyA_user_input", user_input, 32'h000A);
        btn_n[3] = 1'b0;
        hold(2);
        step_tick();
        check("strobe_btn_pulse", btn_pulse, 32'h008);
        check("strobe_user_input", user_input, 32'h000A);
        check("strobe_input_valid", input_valid, 32'd1);
        hold(1);
        check("after_strobe_user_input", user_input, 32'h0);
        check("after_strobe_input_valid", input_valid, 32'h0);
        btn_n[3] = 1'b1;
        hold(4);

        // Bouncing btn[0] must not fire; the following stable run fires once.
        seen0 = 0;
        for (int t = 0; t < 8; t++) begin
            btn_n[0] = 1'(t % 2);
            step_tick();
        end
        check("bounce_no_pulse", seen0, 32'd0);
        btn_n[0] = 1'b0;
        hold(4);
        hold(20);
        check("bounce_single_pulse", seen0, 32'd1);
        btn_n[0] = 1'b1;
        hold(4);

        // Chord in row 2: ignored, scan keeps cycling through every row.
        keys_down = 16'h0900;
        for (int r = 0; r < 4; r++) seen_rows[r] = 0;
        for (int t = 0; t < 8; t++) begin
            step_tick();
            for (int r = 0; r < 4; r++) begin
                pat = ~(4'b0001 << r);
                if (kp_row_n == pat) seen_rows[r]++;
            end
        end
        for (int r = 0; r < 4; r++) check("chord_row_visits", seen_rows[r], 32'd2);
        check("chord_digit_count", digit_count, 32'd0);
        keys_down = '0;
        hold(1);

        // Reset while a key is being debounced, key still held afterwards.
        keys_down = 16'h0200;
        for (int t = 0; t < 8; t++) begin
            step_tick();
            if (!m_locked && m_run == 1) break;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(10);
        keys_down = '0;
        hold(5);
        check("rst_key_user_input", user_input, 32'h0009);
        check("rst_key_digit_count", digit_count, 32'd1);

        // Randomized keys, short taps, chords and button chatter.
        timer = 0;
        for (int t = 0; t < 400; t++) begin
            if (timer == 0) begin
                case ($urandom_range(0, 3))
                    0:       keys_down = '0;
                    1, 2:    keys_down = 16'h0001 << $urandom_range(0, 15);
                    default: keys_down = (16'h0001 << $urandom_range(0, 15)) |
                                         (16'h0001 << $urandom_range(0, 15));
                endcase
                timer = $urandom_range(1, 9);
            end
            timer--;
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, NB - 1);
                btn_n[b] = ~btn_n[b];
            end
            step_tick();
        end
        keys_down = '0;
        btn_n     = '1;
        hold(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/panel_input.md
Name: panel_input

Overview:
- Front-panel input producer for the CPU control/monitor block.
- Scans a 4x4 hex keypad and accumulates typed digits into a 16-bit entry value (user_input / input_valid).
- Debounces the raw function buttons (step, run/halt, reset, load, dec, store-inc, irq, toA/SP/X/Y/PC) into one-clock press pulses.
- Sits between the board I/O pins and the CPU control block's userInput/inputValid/b_* inputs.

Parameters:
- SCAN_DIV, 1000: clk cycles per scan tick; prescaler period.
- DEBOUNCE_CNT, 16: consecutive stable ticks required to accept a press or a release.
- NUM_BTN, 12: number of function buttons.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- kp_row_n  out  4  keypad row drive, active-low, exactly one row low at a time
- kp_col_n  in  4  keypad columns, active-low, externally pulled up, asynchronous
- btn_n  in  NUM_BTN  raw function buttons, active-low, asynchronous
- btn_pulse  out  NUM_BTN  one-clk pulse per debounced press
- user_input  out  16  entered hex value, newest digit in [3:0]
- input_valid  out  1  high when digit_count != 0
- digit_count  out  3  digits entered since last clear, saturates at 4

Behaviour:
- Reset values:
  - kp_row_n=4'b1110; btn_pulse=0; user_input=0; input_valid=0; digit_count=0.
  - Scan FSM in SCAN, row index 0, all debounce counters 0, prescaler 0.
- Synchronisers: kp_col_n and btn_n each pass through 2-FF synchronisers before any use.
- Tick: prescaler counts 0..SCAN_DIV-1 and asserts a one-clk tick at wrap. All debounce counting and row stepping happen only on tick.
- Function buttons, per bit, independent:
  - Counter 0..DEBOUNCE_CNT plus a stable state bit.
  - On tick, if the synced level differs from the stable state, count++; else count=0.
  - When count reaches DEBOUNCE_CNT, the stable state flips and count=0.
  - A stable high->low transition produces btn_pulse high for exactly one clk, the clk after that tick. A release produces no pulse.
  - A held button produces a single pulse only.
- Keypad scan FSM states: SCAN, PRESS, HELD, RELEASE.
  - SCAN: on tick, sample synced cols for the driven row.
    - Exactly one col low: latch row/col and go to PRESS, count=1, row held.
    - Zero cols low, or more than one col low (ghost/chord): ignore; advance row (0->1->2->3->0) and update kp_row_n.
  - PRESS: on tick, if the same single col is still low, count++; else return to SCAN with count=0 and the row advanced.
    - When count reaches DEBOUNCE_CNT: accept key code = {row[1:0], col[1:0]} (0x0..0xF), go to HELD.
  - HELD: on tick, if all cols are high go to RELEASE with count=1. No repeat while held.
  - RELEASE: on tick, if all cols are high, count++; any col low returns to HELD.
    - When count reaches DEBOUNCE_CNT: go to SCAN and advance the row.
- Digit accept, the clk after the accepting tick:
  - user_input <= {user_input[11:0], key}.
  - digit_count <= min(digit_count+1, 4). A 5th and later digit shifts out the oldest digit.
- Consumption:
  - In a clk where any btn_pulse bit is high, user_input and input_valid hold their pre-pulse values, so the consumer samples them with the strobe.
  - On the following clk: user_input=0, digit_count=0.
- Simultaneous events:
  - A digit accepted in the same clk as a btn_pulse is lost, because the clear follows.
  - A digit accepted in the clear clk becomes the first digit of the new entry: user_input=key, digit_count=1.
- Reset mid-scan or mid-debounce: all state returns to reset values immediately. A key still held after reset is re-debounced from SCAN and accepted once.

Decomposition:
- Package panel_pkg:
  - scan FSM state enum (SCAN, PRESS, HELD, RELEASE)
  - KP_ROWS=4 and KP_COLS=4 constants
  - KEY_W=4 and ENTRY_W=16 constants
  - MAX_DIGITS=4
- Sub-module debounce_bit:
  - Contains the synchroniser, counter, stable state and press pulse.
  - Inputs: clk, rst_n, tick, raw_n. Outputs: stable, press_pulse.
  - Instantiated NUM_BTN times.
- The keypad scan FSM stays in panel_input.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Hold key row1/col2 low for 10 ticks, then release for 5 ticks -> one accept; user_input=0x0006, digit_count=1, input_valid=1; no repeat.
- Keys 1,2,3,4,5 in sequence -> user_input=0x2345, digit_count=4.
- Enter 0xA, then press btn[3] -> btn_pulse[3] high 1 clk with user_input=0x000A; next clk user_input=0, input_valid=0.
- btn[0] bouncing low/high every tick for 8 ticks, then low for 4 ticks -> exactly one btn_pulse[0], delayed after the stable run; hold 20 more ticks -> no further pulse.
- Two cols low in the same row -> no digit accepted, scan keeps advancing; kp_row_n cycles 1110,1101,1011,0111.
- Assert rst_n low during PRESS, then release rst_n with the key still held -> all outputs at reset values; exactly one digit accepted after reset.
